// File: rtl/imm_extend.sv
// RV32 decode-stage immediate generator: combinational extended immediate plus a registered copy.
// Optional IMM_EXTEND_ILLEGAL_CHK_EN adds a sticky illegal_src_o flag for the unused select codes.
module imm_extend (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:7] instr_i,
  input  logic [2:0]  imm_src_i,
`ifdef IMM_EXTEND_ILLEGAL_CHK_EN
  output logic        illegal_src_o,
`endif
  output logic [31:0] imm_ext_o,
  output logic [31:0] imm_ext_q_o
);

  localparam logic [2:0] I_EXT   = 3'b000;
  localparam logic [2:0] S_EXT   = 3'b001;
  localparam logic [2:0] B_EXT   = 3'b010;
  localparam logic [2:0] J_EXT   = 3'b011;
  localparam logic [2:0] U_EXT   = 3'b100;
  localparam logic [2:0] CSR_EXT = 3'b101;

  logic        sign_bit;
  logic [31:0] imm_ext_next;
  logic [31:0] imm_ext_reg;

  assign sign_bit = instr_i[31];

  always_comb begin
    imm_ext_next = 32'b0;
    unique case (imm_src_i)
      I_EXT:   imm_ext_next = {{20{sign_bit}}, instr_i[31:20]};
      S_EXT:   imm_ext_next = {{20{sign_bit}}, instr_i[31:25], instr_i[11:7]};
      B_EXT:   imm_ext_next = {{19{sign_bit}}, instr_i[31], instr_i[7],
                               instr_i[30:25], instr_i[11:8], 1'b0};
      J_EXT:   imm_ext_next = {{11{sign_bit}}, instr_i[31], instr_i[19:12],
                               instr_i[20], instr_i[30:21], 1'b0};
      U_EXT:   imm_ext_next = {instr_i[31:12], 12'b0};
      // CSRRxI uimm is an unsigned 5-bit field taken from the rs1 slot
      CSR_EXT: imm_ext_next = {27'b0, instr_i[19:15]};
      default: imm_ext_next = 32'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      imm_ext_reg <= 32'b0;
    end else begin
      imm_ext_reg <= imm_ext_next;
    end
  end

  assign imm_ext_o   = imm_ext_next;
  assign imm_ext_q_o = imm_ext_reg;

`ifdef IMM_EXTEND_ILLEGAL_CHK_EN
  logic illegal_src_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      illegal_src_reg <= 1'b0;
    end else if (imm_src_i[2] && imm_src_i[1]) begin
      illegal_src_reg <= 1'b1;
    end
  end

  assign illegal_src_o = illegal_src_reg;
`endif

endmodule

// File: tb/tb_imm_extend.sv
// Scoreboard bench for imm_extend: a driver queues expected results per transaction,
// a negedge monitor pops and compares the combinational and registered outputs.
module tb_imm_extend;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic        rst;
    logic [31:0] exp_comb;
    logic [31:0] exp_q;
    logic        exp_ill;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:7] instr_i;
  logic [2:0]  imm_src_i;
  logic [31:0] imm_ext_o;
  logic [31:0] imm_ext_q_o;
`ifdef IMM_EXTEND_ILLEGAL_CHK_EN
  logic        illegal_src_o;
`endif

  txn_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          drive_done = 1'b0;
  bit          summary_done = 1'b0;

  logic [31:0] last_comb = 32'b0;
  logic        last_rst  = 1'b1;
  logic        last_bad  = 1'b0;
  logic        ill_model = 1'b0;

  imm_extend dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .instr_i     (instr_i),
    .imm_src_i   (imm_src_i),
`ifdef IMM_EXTEND_ILLEGAL_CHK_EN
    .illegal_src_o (illegal_src_o),
`endif
    .imm_ext_o   (imm_ext_o),
    .imm_ext_q_o (imm_ext_q_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply one vector right after a posedge; the registered expectations describe
  // what the edge just passed should have loaded.
  task automatic drive(input logic [31:0] instr, input logic [2:0] src,
                       input logic rst, input logic [31:0] exp_comb);
    txn_t t;
    @(posedge clk_i);
    #1;
    ill_model = last_rst ? 1'b0 : (ill_model | last_bad);
    t.instr    = instr;
    t.src      = src;
    t.rst      = rst;
    t.exp_comb = exp_comb;
    t.exp_q    = last_rst ? 32'b0 : last_comb;
    t.exp_ill  = ill_model;
    instr_i    = instr[31:7];
    imm_src_i  = src;
    reset_i    = rst;
    sb_q.push_back(t);
    last_comb  = exp_comb;
    last_rst   = rst;
    last_bad   = (src == 3'b110) || (src == 3'b111);
  endtask

  task automatic print_summary();
    if (!summary_done) begin
      summary_done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    end
  endtask

  initial begin
    reset_i   = 1'b1;
    instr_i   = '0;
    imm_src_i = 3'b000;
    drive(32'h12345037, 3'b100, 1'b1, 32'h12345000);
    drive(32'h12345037, 3'b100, 1'b0, 32'h12345000);
    drive(32'hFFF00093, 3'b000, 1'b0, 32'hFFFFFFFF);
    drive(32'h7FF00093, 3'b000, 1'b0, 32'h000007FF);
    drive(32'hFE512E23, 3'b001, 1'b0, 32'hFFFFFFFC);
    drive(32'h00000F80, 3'b001, 1'b0, 32'h0000001F);
    drive(32'h80000063, 3'b010, 1'b0, 32'hFFFFF000);
    drive(32'hFFFFFFFF, 3'b010, 1'b0, 32'hFFFFFFFE);
    drive(32'h80000000, 3'b011, 1'b0, 32'hFFF00000);
    drive(32'hFFFFFFFF, 3'b011, 1'b0, 32'hFFFFFFFE);
    drive(32'hFFFFFFFF, 3'b100, 1'b0, 32'hFFFFF000);
    drive(32'h000D0000, 3'b101, 1'b0, 32'h0000001A);
    drive(32'hFFFD7FFF, 3'b101, 1'b0, 32'h0000001A);
    drive(32'hFFFFFFFF, 3'b110, 1'b0, 32'h00000000);
    drive(32'hFFF00093, 3'b000, 1'b1, 32'hFFFFFFFF);
    drive(32'hFFFFFFFF, 3'b111, 1'b0, 32'h00000000);
    drive(32'h00100093, 3'b000, 1'b0, 32'h00000001);
    drive(32'h00000000, 3'b101, 1'b0, 32'h00000000);
    drive_done = 1'b1;
  end

  initial begin
    txn_t t;
    int   n;
    n = 0;
    while (!(drive_done && sb_q.size() == 0)) begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        t = sb_q.pop_front();
        $display("txn %0d: instr=%h src=%b rst=%b imm=%h imm_q=%h", n, t.instr, t.src,
                 t.rst, imm_ext_o, imm_ext_q_o);
        checks++;
        if (imm_ext_o !== t.exp_comb) begin
          errors++;
          $display("FAIL comb_imm txn %0d: got %h expected %h", n, imm_ext_o, t.exp_comb);
        end
        checks++;
        if (imm_ext_q_o !== t.exp_q) begin
          errors++;
          $display("FAIL reg_imm txn %0d: got %h expected %h", n, imm_ext_q_o, t.exp_q);
        end
`ifdef IMM_EXTEND_ILLEGAL_CHK_EN
        checks++;
        if (illegal_src_o !== t.exp_ill) begin
          errors++;
          $display("FAIL illegal_flag txn %0d: got %b expected %b", n, illegal_src_o, t.exp_ill);
        end
`endif
        n++;
      end
    end
    print_summary();
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, %0d transactions pending", sb_q.size());
    print_summary();
    $finish;
  end

endmodule
